// File: rtl/mk_reg_file_arb.sv
// rtl/mk_reg_file_arb.sv - two-client round-robin arbiter in front of a 1R1W register file
//
// Purpose: each of two clients owns a one-entry read slot, a one-entry write
// slot and a one-entry read-response buffer. Reads and writes are arbitrated
// independently, round-robin, onto the register file's single read port and
// single write port.
//
// Ports:
//   CLK, RST_N                            clock, asynchronous active-low reset
//   EN_rd_cN, rd_cN_x, RDY_rd_cN          client N read request / slot empty
//   EN_wr_cN, wr_cN_x, wr_cN_y, RDY_wr_cN client N write request / slot empty
//   rd_cN, RDY_rdresp_cN, EN_rdresp_cN    client N read response / valid / consume
//   rf_sub_x, rf_EN_sub, rf_sub, rf_RDY_sub          regfile read port
//   rf_upd_x, rf_upd_y, rf_EN_upd, rf_RDY_upd        regfile write port
module mk_reg_file_arb #(
  parameter int size  = 5,
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN_rd_c0,
  input  logic [size-1:0]  rd_c0_x,
  output logic             RDY_rd_c0,
  input  logic             EN_rd_c1,
  input  logic [size-1:0]  rd_c1_x,
  output logic             RDY_rd_c1,
  input  logic             EN_wr_c0,
  input  logic [size-1:0]  wr_c0_x,
  input  logic [width-1:0] wr_c0_y,
  output logic             RDY_wr_c0,
  input  logic             EN_wr_c1,
  input  logic [size-1:0]  wr_c1_x,
  input  logic [width-1:0] wr_c1_y,
  output logic             RDY_wr_c1,
  output logic [width-1:0] rd_c0,
  output logic             RDY_rdresp_c0,
  input  logic             EN_rdresp_c0,
  output logic [width-1:0] rd_c1,
  output logic             RDY_rdresp_c1,
  input  logic             EN_rdresp_c1,
  output logic [size-1:0]  rf_sub_x,
  output logic             rf_EN_sub,
  input  logic [width-1:0] rf_sub,
  input  logic             rf_RDY_sub,
  output logic [size-1:0]  rf_upd_x,
  output logic [width-1:0] rf_upd_y,
  output logic             rf_EN_upd,
  input  logic             rf_RDY_upd
);

  // Client-indexed views of the request ports (index 0 = client 0).
  logic [1:0]             en_rd, en_wr, en_rsp;
  logic [1:0][size-1:0]   rd_x, wr_x;
  logic [1:0][width-1:0]  wr_y;

  assign en_rd  = {EN_rd_c1, EN_rd_c0};
  assign en_wr  = {EN_wr_c1, EN_wr_c0};
  assign en_rsp = {EN_rdresp_c1, EN_rdresp_c0};
  assign rd_x   = {rd_c1_x, rd_c0_x};
  assign wr_x   = {wr_c1_x, wr_c0_x};
  assign wr_y   = {wr_c1_y, wr_c0_y};

  logic [1:0]             rd_v_q, rd_v_d;
  logic [1:0][size-1:0]   rd_a_q, rd_a_d;
  logic [1:0]             wr_v_q, wr_v_d;
  logic [1:0][size-1:0]   wr_a_q, wr_a_d;
  logic [1:0][width-1:0]  wr_d_q, wr_d_d;
  logic [1:0]             rsp_v_q, rsp_v_d;
  logic [1:0][width-1:0]  rsp_d_q, rsp_d_d;
  // Priority bits hold the index of the client that wins a tie.
  logic                   rd_pri_q, rd_pri_d;
  logic                   wr_pri_q, wr_pri_d;

  logic [1:0]             rd_elig, wr_elig;
  logic                   rd_go, wr_go;
  logic                   rd_sel, wr_sel;

  always_comb begin
    rd_v_d   = rd_v_q;
    rd_a_d   = rd_a_q;
    wr_v_d   = wr_v_q;
    wr_a_d   = wr_a_q;
    wr_d_d   = wr_d_q;
    rsp_v_d  = rsp_v_q;
    rsp_d_d  = rsp_d_q;
    rd_pri_d = rd_pri_q;
    wr_pri_d = wr_pri_q;

    // A read waits for its own client's pending write so the client always
    // observes its own writes; the response buffer must be empty at cycle
    // start, so a buffer consumed this cycle is refilled no earlier than next.
    rd_elig = rd_v_q & ~rsp_v_q & ~wr_v_q;
    wr_elig = wr_v_q;

    rd_go  = rf_RDY_sub && (rd_elig != 2'b00);
    rd_sel = (rd_elig == 2'b11) ? rd_pri_q : rd_elig[1];
    wr_go  = rf_RDY_upd && (wr_elig != 2'b00);
    wr_sel = (wr_elig == 2'b11) ? wr_pri_q : wr_elig[1];

    // Enqueue only into empty slots; no same-cycle bypass of a draining slot.
    for (int n = 0; n < 2; n++) begin
      if (en_rd[n] && !rd_v_q[n]) begin
        rd_v_d[n] = 1'b1;
        rd_a_d[n] = rd_x[n];
      end
      if (en_wr[n] && !wr_v_q[n]) begin
        wr_v_d[n] = 1'b1;
        wr_a_d[n] = wr_x[n];
        wr_d_d[n] = wr_y[n];
      end
      if (en_rsp[n] && rsp_v_q[n]) begin
        rsp_v_d[n] = 1'b0;
      end
    end

    // rf_sub is the combinational pre-edge value, so a same-cycle write to the
    // same address is not visible to the read being captured here.
    if (rd_go) begin
      rd_v_d[rd_sel]  = 1'b0;
      rsp_v_d[rd_sel] = 1'b1;
      rsp_d_d[rd_sel] = rf_sub;
      rd_pri_d        = ~rd_sel;
    end
    if (wr_go) begin
      wr_v_d[wr_sel] = 1'b0;
      wr_pri_d       = ~wr_sel;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_v_q   <= '0;
      rd_a_q   <= '0;
      wr_v_q   <= '0;
      wr_a_q   <= '0;
      wr_d_q   <= '0;
      rsp_v_q  <= '0;
      rsp_d_q  <= '0;
      rd_pri_q <= 1'b0;
      wr_pri_q <= 1'b0;
    end else begin
      rd_v_q   <= rd_v_d;
      rd_a_q   <= rd_a_d;
      wr_v_q   <= wr_v_d;
      wr_a_q   <= wr_a_d;
      wr_d_q   <= wr_d_d;
      rsp_v_q  <= rsp_v_d;
      rsp_d_q  <= rsp_d_d;
      rd_pri_q <= rd_pri_d;
      wr_pri_q <= wr_pri_d;
    end
  end

  assign RDY_rd_c0     = ~rd_v_q[0];
  assign RDY_rd_c1     = ~rd_v_q[1];
  assign RDY_wr_c0     = ~wr_v_q[0];
  assign RDY_wr_c1     = ~wr_v_q[1];
  assign RDY_rdresp_c0 = rsp_v_q[0];
  assign RDY_rdresp_c1 = rsp_v_q[1];
  assign rd_c0         = rsp_d_q[0];
  assign rd_c1         = rsp_d_q[1];

  assign rf_EN_sub = rd_go;
  assign rf_sub_x  = rd_go ? rd_a_q[rd_sel] : '0;
  assign rf_EN_upd = wr_go;
  assign rf_upd_x  = wr_go ? wr_a_q[wr_sel] : '0;
  assign rf_upd_y  = wr_go ? wr_d_q[wr_sel] : '0;

endmodule

// File: tb/tb_mk_reg_file_arb.sv
// tb/tb_mk_reg_file_arb.sv - scoreboard bench for mk_reg_file_arb
module tb_mk_reg_file_arb;
  localparam int SZ = 5;
  localparam int WD = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          EN_rd_c0 = 1'b0, EN_rd_c1 = 1'b0;
  logic [SZ-1:0] rd_c0_x = '0, rd_c1_x = '0;
  logic          EN_wr_c0 = 1'b0, EN_wr_c1 = 1'b0;
  logic [SZ-1:0] wr_c0_x = '0, wr_c1_x = '0;
  logic [WD-1:0] wr_c0_y = '0, wr_c1_y = '0;
  logic          EN_rdresp_c0 = 1'b0, EN_rdresp_c1 = 1'b0;
  logic          rf_RDY_sub = 1'b1, rf_RDY_upd = 1'b1;
  logic          RDY_rd_c0, RDY_rd_c1, RDY_wr_c0, RDY_wr_c1;
  logic          RDY_rdresp_c0, RDY_rdresp_c1;
  logic [WD-1:0] rd_c0, rd_c1;
  logic [SZ-1:0] rf_sub_x, rf_upd_x;
  logic [WD-1:0] rf_sub, rf_upd_y;
  logic          rf_EN_sub, rf_EN_upd;

  mk_reg_file_arb #(.size(SZ), .width(WD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_rd_c0(EN_rd_c0), .rd_c0_x(rd_c0_x), .RDY_rd_c0(RDY_rd_c0),
    .EN_rd_c1(EN_rd_c1), .rd_c1_x(rd_c1_x), .RDY_rd_c1(RDY_rd_c1),
    .EN_wr_c0(EN_wr_c0), .wr_c0_x(wr_c0_x), .wr_c0_y(wr_c0_y), .RDY_wr_c0(RDY_wr_c0),
    .EN_wr_c1(EN_wr_c1), .wr_c1_x(wr_c1_x), .wr_c1_y(wr_c1_y), .RDY_wr_c1(RDY_wr_c1),
    .rd_c0(rd_c0), .RDY_rdresp_c0(RDY_rdresp_c0), .EN_rdresp_c0(EN_rdresp_c0),
    .rd_c1(rd_c1), .RDY_rdresp_c1(RDY_rdresp_c1), .EN_rdresp_c1(EN_rdresp_c1),
    .rf_sub_x(rf_sub_x), .rf_EN_sub(rf_EN_sub), .rf_sub(rf_sub), .rf_RDY_sub(rf_RDY_sub),
    .rf_upd_x(rf_upd_x), .rf_upd_y(rf_upd_y), .rf_EN_upd(rf_EN_upd), .rf_RDY_upd(rf_RDY_upd)
  );

  always #5 CLK = ~CLK;

  // Register file model: combinational read, write at the clock edge.
  logic [WD-1:0] mem [32];
  assign rf_sub = mem[rf_sub_x];
  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
      mem[2] <= 32'h22;
      mem[3] <= 32'hA5;
      mem[7] <= 32'h0;
    end else if (rf_EN_upd && rf_RDY_upd) begin
      mem[rf_upd_x] <= rf_upd_y;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard queues: read addresses on the regfile port, {addr,data} writes,
  // and per-client response data.
  logic [SZ-1:0]    q_rda[$];
  logic [SZ+WD-1:0] q_wr[$];
  logic [WD-1:0]    q_rsp0[$];
  logic [WD-1:0]    q_rsp1[$];

  // Monitor: compares every strobe/response against the queues and consumes
  // responses as soon as they are offered.
  always @(negedge CLK) begin
    EN_rdresp_c0 = 1'b0;
    EN_rdresp_c1 = 1'b0;
    if (!RST_N) begin
      chk("mon_quiet_in_reset", {rf_EN_sub, rf_EN_upd, RDY_rdresp_c0, RDY_rdresp_c1}, 4'h0);
    end else begin
      if (rf_EN_sub) begin
        if (q_rda.size() == 0) chk("mon_rd_strobe_unexpected", rf_EN_sub, 1'b0);
        else chk("mon_rd_addr", rf_sub_x, q_rda.pop_front());
      end
      if (rf_EN_upd) begin
        if (q_wr.size() == 0) chk("mon_wr_strobe_unexpected", rf_EN_upd, 1'b0);
        else chk("mon_wr_addr_data", {rf_upd_x, rf_upd_y}, q_wr.pop_front());
      end
      if (RDY_rdresp_c0) begin
        if (q_rsp0.size() == 0) chk("mon_rsp0_unexpected", RDY_rdresp_c0, 1'b0);
        else chk("mon_rsp0_data", rd_c0, q_rsp0.pop_front());
        EN_rdresp_c0 = 1'b1;
      end
      if (RDY_rdresp_c1) begin
        if (q_rsp1.size() == 0) chk("mon_rsp1_unexpected", RDY_rdresp_c1, 1'b0);
        else chk("mon_rsp1_data", rd_c1, q_rsp1.pop_front());
        EN_rdresp_c1 = 1'b1;
      end
    end
  end

  task automatic edge_clear();
    @(posedge CLK);
    #1;
    EN_rd_c0 = 1'b0;
    EN_rd_c1 = 1'b0;
    EN_wr_c0 = 1'b0;
    EN_wr_c1 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_rdy", {RDY_rd_c0, RDY_rd_c1, RDY_wr_c0, RDY_wr_c1}, 4'hF);
    chk("reset_strobes", {RDY_rdresp_c0, RDY_rdresp_c1, rf_EN_sub, rf_EN_upd}, 4'h0);
    chk("reset_data", {rd_c0, rd_c1, rf_sub_x, rf_upd_x, rf_upd_y}, 128'h0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("first_edge_rdy", {RDY_rd_c0, RDY_rd_c1, RDY_wr_c0, RDY_wr_c1}, 4'hF);
    chk("first_edge_outs", {RDY_rdresp_c0, RDY_rdresp_c1, rf_EN_sub, rf_EN_upd, rd_c0, rd_c1}, 68'h0);

    // Single read of addr 3 by client 0.
    @(negedge CLK);
    EN_rd_c0 = 1'b1; rd_c0_x = 5'd3;
    q_rda.push_back(5'd3); q_rsp0.push_back(32'hA5);
    edge_clear();
    chk("single_rd_slot_full", RDY_rd_c0, 1'b0);
    @(negedge CLK);
    chk("single_rd_strobe_t1", {rf_EN_sub, rf_sub_x}, {1'b1, 5'd3});
    @(negedge CLK);
    chk("single_rd_rsp_t2", {RDY_rdresp_c0, rd_c0}, {1'b1, 32'hA5});
    @(negedge CLK);
    chk("single_rd_consumed_hold", {RDY_rdresp_c0, rd_c0}, {1'b0, 32'hA5});

    // Write contention, priority at client 0.
    @(negedge CLK);
    EN_wr_c0 = 1'b1; wr_c0_x = 5'd10; wr_c0_y = 32'h100;
    EN_wr_c1 = 1'b1; wr_c1_x = 5'd11; wr_c1_y = 32'h111;
    q_wr.push_back({5'd10, 32'h100}); q_wr.push_back({5'd11, 32'h111});
    edge_clear();
    @(negedge CLK);
    chk("contend_c0_first", {rf_EN_upd, rf_upd_x}, {1'b1, 5'd10});
    @(negedge CLK);
    chk("contend_c1_second", {rf_EN_upd, rf_upd_x}, {1'b1, 5'd11});
    // Lone c0 write leaves priority with client 1 for the repeated pair.
    @(negedge CLK);
    EN_wr_c0 = 1'b1; wr_c0_x = 5'd12; wr_c0_y = 32'h120;
    q_wr.push_back({5'd12, 32'h120});
    edge_clear();
    @(negedge CLK);
    chk("lone_c0_write", {rf_EN_upd, rf_upd_x}, {1'b1, 5'd12});
    @(negedge CLK);
    EN_wr_c0 = 1'b1; wr_c0_x = 5'd13; wr_c0_y = 32'h130;
    EN_wr_c1 = 1'b1; wr_c1_x = 5'd14; wr_c1_y = 32'h140;
    q_wr.push_back({5'd14, 32'h140}); q_wr.push_back({5'd13, 32'h130});
    edge_clear();
    @(negedge CLK);
    chk("repeat_c1_first", {rf_EN_upd, rf_upd_x}, {1'b1, 5'd14});
    @(negedge CLK);
    chk("repeat_c0_second", {rf_EN_upd, rf_upd_x}, {1'b1, 5'd13});

    // Own read-after-write for client 1.
    @(negedge CLK);
    EN_wr_c1 = 1'b1; wr_c1_x = 5'd7; wr_c1_y = 32'h11;
    EN_rd_c1 = 1'b1; rd_c1_x = 5'd7;
    q_wr.push_back({5'd7, 32'h11}); q_rda.push_back(5'd7); q_rsp1.push_back(32'h11);
    edge_clear();
    @(negedge CLK);
    chk("raw_t1_write_only", {rf_EN_upd, rf_EN_sub}, 2'b10);
    @(negedge CLK);
    chk("raw_t2_read", {rf_EN_sub, rf_sub_x}, {1'b1, 5'd7});
    @(negedge CLK);
    chk("raw_rsp", {RDY_rdresp_c1, rd_c1}, {1'b1, 32'h11});

    // Cross-client hazard: same-cycle read and write of addr 2.
    @(negedge CLK);
    EN_rd_c0 = 1'b1; rd_c0_x = 5'd2;
    EN_wr_c1 = 1'b1; wr_c1_x = 5'd2; wr_c1_y = 32'h55;
    q_rda.push_back(5'd2); q_wr.push_back({5'd2, 32'h55}); q_rsp0.push_back(32'h22);
    edge_clear();
    @(negedge CLK);
    chk("cross_both_grants", {rf_EN_sub, rf_EN_upd, rf_sub_x, rf_upd_x}, {2'b11, 5'd2, 5'd2});
    @(negedge CLK);
    chk("cross_old_value", {RDY_rdresp_c0, rd_c0}, {1'b1, 32'h22});
    @(negedge CLK);
    EN_rd_c1 = 1'b1; rd_c1_x = 5'd2;
    q_rda.push_back(5'd2); q_rsp1.push_back(32'h55);
    edge_clear();
    @(negedge CLK);
    @(negedge CLK);
    chk("cross_readback_new", {RDY_rdresp_c1, rd_c1}, {1'b1, 32'h55});

    // Write backpressure; an enqueue into the full slot must be dropped.
    @(negedge CLK);
    rf_RDY_upd = 1'b0;
    EN_wr_c0 = 1'b1; wr_c0_x = 5'd20; wr_c0_y = 32'h200;
    q_wr.push_back({5'd20, 32'h200});
    edge_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_stalled", {rf_EN_upd, RDY_wr_c0}, 2'b00);
      if (i == 0) begin
        EN_wr_c0 = 1'b1; wr_c0_x = 5'd21; wr_c0_y = 32'h211;
      end
      edge_clear();
    end
    rf_RDY_upd = 1'b1;
    @(negedge CLK);
    chk("bp_grant_on_rise", {rf_EN_upd, rf_upd_x, rf_upd_y}, {1'b1, 5'd20, 32'h200});

    // Asynchronous reset between grant and capture.
    @(negedge CLK);
    EN_rd_c0 = 1'b1; rd_c0_x = 5'd3;
    EN_rd_c1 = 1'b1; rd_c1_x = 5'd2;
    EN_wr_c1 = 1'b1; wr_c1_x = 5'd9; wr_c1_y = 32'h99;
    q_rda.push_back(5'd3); q_wr.push_back({5'd9, 32'h99});
    edge_clear();
    @(negedge CLK);
    chk("rst_pre_grants", {rf_EN_sub, rf_EN_upd, RDY_rd_c1, RDY_wr_c1}, 4'b1100);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_rdy", {RDY_rd_c0, RDY_rd_c1, RDY_wr_c0, RDY_wr_c1}, 4'hF);
    chk("rst_async_outs", {rf_EN_sub, rf_EN_upd, RDY_rdresp_c0, RDY_rdresp_c1}, 4'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_idle", {rf_EN_sub, rf_EN_upd, RDY_rdresp_c0, RDY_rdresp_c1,
                            RDY_rd_c0, RDY_rd_c1, RDY_wr_c0, RDY_wr_c1}, 8'h0F);
    end

    chk("drain_rd_addr", q_rda.size(), 0);
    chk("drain_wr", q_wr.size(), 0);
    chk("drain_rsp0", q_rsp0.size(), 0);
    chk("drain_rsp1", q_rsp1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
